// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port, synchronous-read unified memory
//                between the MIPS instruction-fetch port (I) and data port
//                (D). Each access runs ACCESS (memory strobe) then RESP
//                (acknowledge + read data). D has fixed priority; a
//                starvation counter hands the memory to a waiting fetch after
//                STARVE_LIMIT consecutive data grants.
//
//  Ports       : clk, rst (synchronous, active-low)
//                i_req/i_addr          -> i_ack/i_rdata      fetch port
//                d_req/d_we/d_addr/
//                d_wdata               -> d_ack/d_rdata      data port
//                mem_en/mem_we/mem_addr/mem_wdata (registered strobes)
//                mem_rdata                                   memory read data
//
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int WIDTH        = 32,
    parameter int ADDRBITS     = 14,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDRBITS-1:0] i_addr,
    output logic                i_ack,
    output logic [WIDTH-1:0]    i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDRBITS-1:0] d_addr,
    input  logic [WIDTH-1:0]    d_wdata,
    output logic                d_ack,
    output logic [WIDTH-1:0]    d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDRBITS-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic       c_OWN_I = 1'b0;
    localparam logic       c_OWN_D = 1'b1;
    localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_owner;
    logic [3:0] r_scnt;
    logic       r_dwr;      // current D access is a write: its rdata reads 0

    logic       w_arb;
    logic       w_i_elig;
    logic       w_d_elig;
    logic       w_grant;
    logic       w_win;
    logic [3:0] w_scnt_nxt;

    // Arbitration and next-state logic
    always_comb begin
        w_arb       = 1'b0;
        w_i_elig    = 1'b0;
        w_d_elig    = 1'b0;
        w_grant     = 1'b0;
        w_win       = c_OWN_D;
        w_scnt_nxt  = 4'd0;
        w_state_nxt = r_state;

        w_arb = (r_state == ST_IDLE) || (r_state == ST_RESP);
        // In RESP the owner's req is still high for the transaction being
        // acknowledged, so it must not win a second grant from it.
        w_i_elig = i_req && !((r_state == ST_RESP) && (r_owner == c_OWN_I));
        w_d_elig = d_req && !((r_state == ST_RESP) && (r_owner == c_OWN_D));
        w_grant  = w_arb && (w_i_elig || w_d_elig);

        if (w_i_elig && w_d_elig) begin
            w_win = (r_scnt == c_LIMIT) ? c_OWN_I : c_OWN_D;
        end else if (w_d_elig) begin
            w_win = c_OWN_D;
        end else begin
            w_win = c_OWN_I;
        end

        // Count only data grants that a pending fetch had to wait behind.
        if ((w_win == c_OWN_D) && i_req) begin
            w_scnt_nxt = (r_scnt >= c_LIMIT) ? c_LIMIT : r_scnt + 4'd1;
        end

        case (r_state)
            ST_IDLE:   w_state_nxt = w_grant ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = w_grant ? ST_ACCESS : ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State, owner, counter and registered memory interface
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= c_OWN_I;
            r_scnt    <= 4'd0;
            r_dwr     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            mem_en  <= w_grant;
            mem_we  <= w_grant && (w_win == c_OWN_D) && d_we;
            if (w_grant) begin
                r_owner <= w_win;
                r_scnt  <= w_scnt_nxt;
                r_dwr   <= (w_win == c_OWN_D) && d_we;
                if (w_win == c_OWN_D) begin
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end else begin
                    mem_addr  <= i_addr;
                    mem_wdata <= '0;
                end
            end
        end
    end

    // RESP is a Moore state: acks and read data follow the owner register.
    always_comb begin
        i_ack   = 1'b0;
        d_ack   = 1'b0;
        i_rdata = '0;
        d_rdata = '0;
        if (r_state == ST_RESP) begin
            if (r_owner == c_OWN_I) begin
                i_ack   = 1'b1;
                i_rdata = mem_rdata;
            end else begin
                d_ack   = 1'b1;
                d_rdata = r_dwr ? '0 : mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire
